// File: rtl/core_bus_pkg.sv
// Shared definitions for the core bus decoder: default memory map, the
// response-tag index width, and the region-hit function.
package core_bus_pkg;

   localparam logic [31:0] INST_BASE   = 32'h0000_0000;
   localparam logic [31:0] DATA_BASE   = 32'hFFFF_0000;
   localparam logic [31:0] PERI_BASE   = 32'hFFFF_1000;
   localparam logic [31:0] PERI2_BASE  = 32'hFFFF_2000;
   localparam logic [31:0] REGION_LEN  = 32'h0000_1000;

   localparam logic [127:0] DEF_SLV_BASE = {PERI2_BASE, PERI_BASE, DATA_BASE, INST_BASE};
   localparam logic [127:0] DEF_SLV_LEN  = {4{REGION_LEN}};

   // Response tag is {err, idx}; idx needs at least one bit even for a single slave.
   function automatic int idx_width(input int num_slv);
      return (num_slv > 1) ? $clog2(num_slv) : 1;
   endfunction

   // Operands are zero-extended to 64 bits, so base+len never wraps for addresses up to 64 bits.
   function automatic logic region_hit(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input logic [63:0] len);
      logic [64:0] w_end;
      w_end = {1'b0, base} + {1'b0, len};
      return (len != 64'd0) && (addr >= base) && ({1'b0, addr} < w_end);
   endfunction

endpackage

// File: rtl/core_bus_decoder_if.sv
// Bus bundle between the requesting core, the decoder and the slave regions.
// The master modport is the environment view (requester plus slaves); the slave modport is the decoder view.
interface core_bus_decoder_if #(
   parameter int NUM_SLV    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = 4
);
   logic                          m_req_vld;
   logic                          m_req_rdy;
   logic [ADDR_WIDTH-1:0]         m_addr;
   logic [DATA_WIDTH-1:0]         m_wdata;
   logic [STRB_WIDTH-1:0]         m_wen;
   logic                          m_rsp_vld;
   logic [DATA_WIDTH-1:0]         m_rsp_rdata;
   logic                          m_rsp_err;

   logic [NUM_SLV-1:0]            s_req_vld;
   logic [NUM_SLV-1:0]            s_req_rdy;
   logic [ADDR_WIDTH-1:0]         s_addr;
   logic [DATA_WIDTH-1:0]         s_wdata;
   logic [STRB_WIDTH-1:0]         s_wen;
   logic [NUM_SLV-1:0]            s_rsp_vld;
   logic [NUM_SLV*DATA_WIDTH-1:0] s_rsp_rdata;

   modport master (
      output m_req_vld, m_addr, m_wdata, m_wen,
      input  m_req_rdy, m_rsp_vld, m_rsp_rdata, m_rsp_err,
      output s_req_rdy, s_rsp_vld, s_rsp_rdata,
      input  s_req_vld, s_addr, s_wdata, s_wen
   );

   modport slave (
      input  m_req_vld, m_addr, m_wdata, m_wen,
      output m_req_rdy, m_rsp_vld, m_rsp_rdata, m_rsp_err,
      input  s_req_rdy, s_rsp_vld, s_rsp_rdata,
      output s_req_vld, s_addr, s_wdata, s_wen
   );
endinterface

// File: rtl/core_bus_outs_fifo.sv
// In-order tracker for outstanding requests: synchronous FIFO whose head is visible combinationally.
// Push is ignored when full and pop is ignored when empty.
module core_bus_outs_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_head    = r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

   // Depth is a power of two, so the pointers wrap on their own.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/core_bus_decoder.sv
// Address decoder routing one master port to NUM_SLV mapped regions, with in-order
// outstanding tracking, registered responses and decode-error completion for unmapped accesses.
module core_bus_decoder
   import core_bus_pkg::*;
#(
   parameter int NUM_SLV    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int STRB_WIDTH = DATA_WIDTH / BYTE_WIDTH,
   parameter int MAX_OUTS   = 4,
   parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE = DEF_SLV_BASE,
   parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_LEN  = DEF_SLV_LEN
) (
   input  logic              CLK,
   input  logic              RSTN,
   core_bus_decoder_if.slave bus,
   output logic              proto_err
);
   localparam int IDX_W = idx_width(NUM_SLV);

   typedef struct packed {
      logic             err;
      logic [IDX_W-1:0] idx;
   } tag_t;

   logic [NUM_SLV-1:0]    w_hits;
   logic                  w_hit;
   logic [IDX_W-1:0]      w_sel;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_rdy;
   logic                  w_push;
   logic                  w_pop;
   tag_t                  w_push_tag;
   tag_t                  w_head;
   logic [NUM_SLV-1:0]    w_s_req_vld;
   logic [NUM_SLV-1:0]    w_expect_mask;
   logic [DATA_WIDTH-1:0] w_slv_rdata;

   logic                  r_rsp_vld;
   logic                  r_rsp_err;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_proto_err;

   for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_hit
      assign w_hits[gi] = region_hit(64'(bus.m_addr),
                                     64'(SLV_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                                     64'(SLV_LEN[gi*ADDR_WIDTH +: ADDR_WIDTH]));
   end

   // Scan downwards so the lowest matching index wins on overlapping regions.
   always_comb begin
      w_sel = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if (w_hits[i]) w_sel = IDX_W'(i);
      end
   end

   assign w_hit = |w_hits;

   always_comb begin
      w_s_req_vld = '0;
      if (w_hit) w_s_req_vld[w_sel] = bus.m_req_vld & ~w_full;
   end

   assign w_rdy           = ~w_full & (w_hit ? bus.s_req_rdy[w_sel] : 1'b1);
   assign w_push          = bus.m_req_vld & w_rdy;
   assign w_push_tag      = {~w_hit, w_sel};

   assign bus.s_req_vld   = w_s_req_vld;
   assign bus.s_addr      = w_hit ? bus.m_addr  : '0;
   assign bus.s_wdata     = w_hit ? bus.m_wdata : '0;
   assign bus.s_wen       = w_hit ? bus.m_wen   : '0;
   assign bus.m_req_rdy   = w_rdy;

   core_bus_outs_fifo #(
      .WIDTH ($bits(tag_t)),
      .DEPTH (MAX_OUTS)
   ) u_outs_fifo (
      .i_clk   (CLK),
      .i_rst_n (RSTN),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_push_tag),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Only the slave owning a live, mapped head entry may respond; anything else is a protocol error.
   always_comb begin
      w_expect_mask = '0;
      if (!w_empty && !w_head.err) w_expect_mask[w_head.idx] = 1'b1;
   end

   assign w_pop       = ~w_empty & (w_head.err | bus.s_rsp_vld[w_head.idx]);
   assign w_slv_rdata = bus.s_rsp_rdata[int'(w_head.idx)*DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_rsp_vld   <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_rsp_vld <= w_pop;
         if (w_pop) begin
            r_rsp_err   <= w_head.err;
            r_rsp_rdata <= w_head.err ? '0 : w_slv_rdata;
         end
         if (|(bus.s_rsp_vld & ~w_expect_mask)) r_proto_err <= 1'b1;
      end
   end

   assign bus.m_rsp_vld   = r_rsp_vld;
   assign bus.m_rsp_err   = r_rsp_err;
   assign bus.m_rsp_rdata = r_rsp_rdata;
   assign proto_err       = r_proto_err;
endmodule

// File: tb/tb_core_bus_decoder.sv
// Directed bench for core_bus_decoder: a queue-based model checked every cycle plus literal spot checks.
module tb_core_bus_decoder;
   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int MO = 4;

   logic CLK  = 1'b0;
   logic RSTN = 1'b0;
   logic proto_err;

   core_bus_decoder_if #(.NUM_SLV(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) bus();

   core_bus_decoder #(
      .NUM_SLV    (NS),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .BYTE_WIDTH (8),
      .STRB_WIDTH (SW),
      .MAX_OUTS   (MO),
      .SLV_BASE   ({32'hFFFF_2000, 32'hFFFF_1000, 32'hFFFF_0000, 32'h0000_0000}),
      .SLV_LEN    ({4{32'h0000_1000}})
   ) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .bus       (bus),
      .proto_err (proto_err)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory map as plain numbers: slot i covers [base, base+0x1000).
   longint unsigned map_base [NS] = '{64'h0000_0000, 64'hFFFF_0000, 64'hFFFF_1000, 64'hFFFF_2000};
   longint unsigned map_len  [NS] = '{64'h1000, 64'h1000, 64'h1000, 64'h1000};

   function automatic int decode(input longint unsigned a);
      for (int i = 0; i < NS; i++) begin
         if (map_len[i] != 0 && a >= map_base[i] && a < map_base[i] + map_len[i]) return i;
      end
      return -1;
   endfunction

   typedef struct {
      bit err;
      int idx;
   } ent_t;

   ent_t            outq[$];
   logic            exp_vld   = 1'b0;
   logic            exp_err   = 1'b0;
   logic [DW-1:0]   exp_rdata = '0;
   logic            exp_proto = 1'b0;

   // Inputs change just after posedge, so at negedge they are what the next posedge will sample.
   always @(negedge CLK) begin : model_check
      int            s;
      bit            full;
      bit            rdy;
      logic [NS-1:0] svld;
      logic [NS-1:0] stray;
      ent_t          e;
      if (!RSTN) begin
         outq.delete();
         exp_vld   = 1'b0;
         exp_err   = 1'b0;
         exp_rdata = '0;
         exp_proto = 1'b0;
      end
      s    = decode(longint'(bus.m_addr));
      full = (outq.size() == MO);
      rdy  = !full && (s < 0 || bus.s_req_rdy[s] == 1'b1);
      svld = '0;
      if (s >= 0 && bus.m_req_vld && !full) svld[s] = 1'b1;

      chk("m_req_rdy",   bus.m_req_rdy,   rdy);
      chk("s_req_vld",   bus.s_req_vld,   svld);
      chk("s_addr",      bus.s_addr,      (s >= 0) ? bus.m_addr  : 32'h0);
      chk("s_wdata",     bus.s_wdata,     (s >= 0) ? bus.m_wdata : 32'h0);
      chk("s_wen",       bus.s_wen,       (s >= 0) ? bus.m_wen   : 4'h0);
      chk("m_rsp_vld",   bus.m_rsp_vld,   exp_vld);
      chk("m_rsp_err",   bus.m_rsp_err,   exp_err);
      chk("m_rsp_rdata", bus.m_rsp_rdata, exp_rdata);
      chk("proto_err",   proto_err,       exp_proto);
      if (bus.m_rsp_vld) $display("rsp  err=%0d rdata=%08h t=%0t", bus.m_rsp_err, bus.m_rsp_rdata, $time);

      if (RSTN) begin
         stray   = bus.s_rsp_vld;
         exp_vld = 1'b0;
         if (outq.size() > 0) begin
            if (outq[0].err) begin
               exp_vld   = 1'b1;
               exp_err   = 1'b1;
               exp_rdata = '0;
               void'(outq.pop_front());
            end else begin
               stray[outq[0].idx] = 1'b0;
               if (bus.s_rsp_vld[outq[0].idx]) begin
                  exp_vld   = 1'b1;
                  exp_err   = 1'b0;
                  exp_rdata = bus.s_rsp_rdata[outq[0].idx*DW +: DW];
                  void'(outq.pop_front());
               end
            end
         end
         if (stray != '0) exp_proto = 1'b1;
         if (bus.m_req_vld && rdy) begin
            e.err = (s < 0);
            e.idx = (s < 0) ? 0 : s;
            outq.push_back(e);
            $display("req  addr=%08h wen=%04b slave=%0d t=%0t", bus.m_addr, bus.m_wen, s, $time);
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
      bus.m_req_vld = 1'b1;
      bus.m_addr    = a;
      bus.m_wdata   = d;
      bus.m_wen     = w;
   endtask

   task automatic slv_rsp(input int i, input logic [31:0] d);
      bus.s_rsp_vld                = '0;
      bus.s_rsp_vld[i]             = 1'b1;
      bus.s_rsp_rdata[i*DW +: DW]  = d;
   endtask

   task automatic respond(input string name, input int i, input logic [31:0] d);
      slv_rsp(i, d);
      step();
      bus.s_rsp_vld = '0;
      #1;
      chk({name, " vld"},   bus.m_rsp_vld,   1'b1);
      chk({name, " rdata"}, bus.m_rsp_rdata, d);
   endtask

   initial begin
      bus.m_req_vld   = 1'b0;
      bus.m_addr      = '0;
      bus.m_wdata     = '0;
      bus.m_wen       = '0;
      bus.s_req_rdy   = '1;
      bus.s_rsp_vld   = '0;
      bus.s_rsp_rdata = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("reset m_rsp_vld",   bus.m_rsp_vld,   1'b0);
      chk("reset m_rsp_rdata", bus.m_rsp_rdata, 32'h0);
      chk("reset proto_err",   proto_err,       1'b0);
      chk("reset m_req_rdy",   bus.m_req_rdy,   1'b1);
      RSTN = 1'b1;
      step();

      // Region edges probed with no request pending.
      bus.m_addr = 32'h0000_0FFF; #1; chk("edge slot0 last", bus.s_addr, 32'h0000_0FFF);
      bus.m_addr = 32'hFFFF_0FFF; #1; chk("edge slot1 last", bus.s_addr, 32'hFFFF_0FFF);
      bus.m_addr = 32'hFFFF_3000; #1; chk("edge past slot3", bus.s_addr, 32'h0);
      bus.m_addr = 32'h0000_1000; #1; chk("edge past slot0", bus.s_addr, 32'h0);
      step();

      // Read slave 1, response two cycles after the request cycle.
      req(32'hFFFF_0004, 32'h0, 4'h0); #1;
      chk("rd1 s_req_vld", bus.s_req_vld, 4'b0010);
      step(); bus.m_req_vld = 1'b0;
      step();
      slv_rsp(1, 32'hDEAD_BEEF); #1;
      chk("rd1 no early rsp", bus.m_rsp_vld, 1'b0);
      step(); bus.s_rsp_vld = '0; #1;
      chk("rd1 vld",   bus.m_rsp_vld,   1'b1);
      chk("rd1 rdata", bus.m_rsp_rdata, 32'hDEAD_BEEF);
      chk("rd1 err",   bus.m_rsp_err,   1'b0);
      step();
      chk("rd1 pulse", bus.m_rsp_vld,   1'b0);
      chk("rd1 hold",  bus.m_rsp_rdata, 32'hDEAD_BEEF);

      // 0xFFFF_1004 lands in slot 2.
      req(32'hFFFF_1004, 32'h0, 4'h0); #1;
      chk("rd2 s_req_vld", bus.s_req_vld, 4'b0100);
      step(); bus.m_req_vld = 1'b0;
      respond("rd2", 2, 32'h1234_5678);
      step();

      // Unmapped access completes by itself with an error.
      req(32'h8000_0000, 32'h0, 4'h0); #1;
      chk("miss rdy",       bus.m_req_rdy, 1'b1);
      chk("miss s_req_vld", bus.s_req_vld, 4'b0000);
      step(); bus.m_req_vld = 1'b0; #1;
      chk("miss not yet", bus.m_rsp_vld, 1'b0);
      step(); #1;
      chk("miss vld",   bus.m_rsp_vld,   1'b1);
      chk("miss err",   bus.m_rsp_err,   1'b1);
      chk("miss rdata", bus.m_rsp_rdata, 32'h0);
      step();

      // Fill the tracker, then a fifth request must wait for the first pop.
      req(32'h0000_0010, 32'h0, 4'h0); step();
      req(32'hFFFF_1020, 32'h0, 4'h0); step();
      req(32'h0000_0030, 32'h0, 4'h0); step();
      req(32'hFFFF_1040, 32'h0, 4'h0); step();
      req(32'hFFFF_0000, 32'h0, 4'h0); #1;
      chk("full rdy",       bus.m_req_rdy, 1'b0);
      chk("full s_req_vld", bus.s_req_vld, 4'b0000);
      step(); #1;
      chk("full rdy hold", bus.m_req_rdy, 1'b0);
      slv_rsp(0, 32'h1111_1111); #1;
      chk("full rdy during pop", bus.m_req_rdy, 1'b0);
      step(); bus.s_rsp_vld = '0; #1;
      chk("full rsp1 rdata", bus.m_rsp_rdata, 32'h1111_1111);
      chk("full rdy after pop", bus.m_req_rdy, 1'b1);
      step(); bus.m_req_vld = 1'b0;
      respond("ord2", 2, 32'h2222_2222);
      respond("ord3", 0, 32'h3333_3333);
      respond("ord4", 2, 32'h4444_4444);
      respond("ord5", 1, 32'h5555_5555);
      step();

      // Stray response from a non-head slave.
      req(32'h0000_0100, 32'h0, 4'h0); step(); bus.m_req_vld = 1'b0;
      slv_rsp(2, 32'hBAD0_BAD0);
      step(); bus.s_rsp_vld = '0; #1;
      chk("proto set",    proto_err,     1'b1);
      chk("proto no rsp", bus.m_rsp_vld, 1'b0);
      step(); step(); #1;
      chk("proto sticky", proto_err, 1'b1);
      // Zero-latency: new request pushed while the head slave answers.
      req(32'hFFFF_2008, 32'h0, 4'h0);
      slv_rsp(0, 32'hA0A0_A0A0);
      step(); bus.m_req_vld = 1'b0; bus.s_rsp_vld = '0; #1;
      chk("zl vld",   bus.m_rsp_vld,   1'b1);
      chk("zl rdata", bus.m_rsp_rdata, 32'hA0A0_A0A0);
      respond("zl slv3", 3, 32'h3333_0003);
      step();

      // Write stalled by slave 3 for three cycles.
      bus.s_req_rdy = 4'b0111;
      req(32'hFFFF_2000, 32'hCAFE_F00D, 4'b0011);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall rdy",   bus.m_req_rdy, 1'b0);
         chk("stall s_wen", bus.s_wen,     4'b0011);
         chk("stall s_vld", bus.s_req_vld, 4'b1000);
         step();
      end
      bus.s_req_rdy = '1; #1;
      chk("stall release rdy", bus.m_req_rdy, 1'b1);
      step(); bus.m_req_vld = 1'b0;
      respond("wr ack", 3, 32'h0);
      step();

      // Reset with two requests outstanding.
      req(32'h0000_0040, 32'h0, 4'h0); step();
      req(32'hFFFF_0040, 32'h0, 4'h0); step();
      bus.m_req_vld = 1'b0;
      #1; RSTN = 1'b0; #1;
      chk("rst vld",   bus.m_rsp_vld,   1'b0);
      chk("rst rdata", bus.m_rsp_rdata, 32'h0);
      chk("rst err",   bus.m_rsp_err,   1'b0);
      chk("rst proto", proto_err,       1'b0);
      chk("rst rdy",   bus.m_req_rdy,   1'b1);
      step(); step();
      RSTN = 1'b1;
      req(32'hFFFF_1050, 32'h0, 4'h0); #1;
      chk("post rst rdy",   bus.m_req_rdy, 1'b1);
      chk("post rst s_vld", bus.s_req_vld, 4'b0100);
      step(); bus.m_req_vld = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("no stale rsp", bus.m_rsp_vld, 1'b0);
         step();
      end
      respond("post rst", 2, 32'h5A5A_5A5A);
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
